// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults, FSM states and operand element indices for the 2x2 systolic feeder
package systolic_pkg;
  localparam int DEF_DW = 8;
  localparam int DEF_DRAIN_MAX = 8;
  typedef enum logic [1:0] {IDLE, LOAD, FEED, DRAIN} state_t;
  localparam logic [2:0] IDX_A00 = 3'd0;
  localparam logic [2:0] IDX_A01 = 3'd1;
  localparam logic [2:0] IDX_A10 = 3'd2;
  localparam logic [2:0] IDX_A11 = 3'd3;
  localparam logic [2:0] IDX_B00 = 3'd4;
  localparam logic [2:0] IDX_B01 = 3'd5;
  localparam logic [2:0] IDX_B10 = 3'd6;
  localparam logic [2:0] IDX_B11 = 3'd7;
endpackage

// File: rtl/systolic_operand_buf.sv
// systolic_operand_buf: 8-entry operand store with a registered skew mux selected by feed phase (3 = idle zeros)
module systolic_operand_buf
  import systolic_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [2:0]    i_widx,
  input  logic [DW-1:0] i_wdata,
  input  logic [1:0]    i_sel,
  output logic [DW-1:0] o_a1,
  output logic [DW-1:0] o_a2,
  output logic [DW-1:0] o_b1,
  output logic [DW-1:0] o_b2
);
  logic [DW-1:0] r_mem [8];
  // capture elements; contents need no reset because the load count decides what is valid
  always_ff @(posedge clk)
    if (i_we) r_mem[i_widx] <= i_wdata;
  // drive the skewed row/column pattern for the requested phase, zeros otherwise
  always_ff @(posedge clk)
    if (rst) begin
      o_a1 <= '0;
      o_a2 <= '0;
      o_b1 <= '0;
      o_b2 <= '0;
    end else begin
      o_a1 <= i_sel == 2'd0 ? r_mem[IDX_A00] : i_sel == 2'd1 ? r_mem[IDX_A01] : '0;
      o_b1 <= i_sel == 2'd0 ? r_mem[IDX_B00] : i_sel == 2'd1 ? r_mem[IDX_B10] : '0;
      o_a2 <= i_sel == 2'd1 ? r_mem[IDX_A10] : i_sel == 2'd2 ? r_mem[IDX_A11] : '0;
      o_b2 <= i_sel == 2'd1 ? r_mem[IDX_B01] : i_sel == 2'd2 ? r_mem[IDX_B11] : '0;
    end
endmodule

// File: rtl/systolic_feeder_2x2.sv
// systolic_feeder_2x2: buffers A/B operand bytes and feeds them skewed into the 2x2 core; FEEDER_PINGPONG_EN adds a second buffer
module systolic_feeder_2x2
  import systolic_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int DRAIN_MAX = DEF_DRAIN_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          arr_done,
  output logic          arr_run,
  output logic [DW-1:0] a1,
  output logic [DW-1:0] a2,
  output logic [DW-1:0] b1,
  output logic [DW-1:0] b2,
  output logic          busy,
  output logic          timeout_err
);
  localparam int WW = $clog2(DRAIN_MAX + 1);
  state_t        r_state;
  logic [2:0]    r_cnt;
  logic [1:0]    r_phase;
  logic [WW-1:0] r_wait;
  logic          r_tmo;
  logic          w_xfer, w_last, w_idle, w_start;
  logic [1:0]    w_sel;
  assign w_xfer = in_valid && in_ready;
  assign w_last = w_xfer && r_cnt == 3'd7;
  assign w_idle = r_state == IDLE || r_state == LOAD;
  assign w_sel = w_start ? 2'd0 : (r_state == FEED && r_phase != 2'd2) ? r_phase + 2'd1 : 2'd3;
  assign arr_run = r_state == FEED || r_state == DRAIN;
  assign busy = arr_run;
  assign timeout_err = r_tmo;
  // job sequencing: load eight elements, feed three phases, then wait for the core to finish
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_phase <= '0;
      r_wait  <= '0;
      r_tmo   <= 1'b0;
    end else begin
      if (w_xfer) r_cnt <= r_cnt + 3'd1;
      case (r_state)
        IDLE, LOAD:
          if (w_start) begin
            r_state <= FEED;
            r_phase <= 2'd0;
          end else if (w_xfer) r_state <= LOAD;
        FEED:
          if (r_phase == 2'd2) begin
            r_state <= DRAIN;
            r_wait  <= '0;
          end else r_phase <= r_phase + 2'd1;
        DRAIN:
          if (arr_done) r_state <= IDLE;
          else if (r_wait == WW'(DRAIN_MAX - 1)) begin
            r_tmo   <= 1'b1;
            r_state <= IDLE;
          end else r_wait <= r_wait + 1'b1;
      endcase
    end
`ifdef FEEDER_PINGPONG_EN
  logic          r_lsel, r_fsel, w_fbuf;
  logic [1:0]    r_full;
  logic [DW-1:0] w_a1 [2];
  logic [DW-1:0] w_a2 [2];
  logic [DW-1:0] w_b1 [2];
  logic [DW-1:0] w_b2 [2];
  assign w_start = w_idle && (w_last || r_full[r_lsel]);
  assign in_ready = !r_full[r_lsel];
  assign w_fbuf = w_start ? r_lsel : r_fsel;
  // a full load-side buffer waits for the feed side; starting a job swaps the roles
  always_ff @(posedge clk)
    if (rst) begin
      r_lsel <= 1'b0;
      r_fsel <= 1'b0;
      r_full <= '0;
    end else if (w_start) begin
      r_fsel         <= r_lsel;
      r_lsel         <= !r_lsel;
      r_full[r_lsel] <= 1'b0;
    end else if (w_last) r_full[r_lsel] <= 1'b1;
  for (genvar i = 0; i < 2; i++) begin : g_buf
    systolic_operand_buf #(.DW(DW)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_xfer && r_lsel == 1'(i)),
      .i_widx  (r_cnt),
      .i_wdata (in_data),
      .i_sel   (w_fbuf == 1'(i) ? w_sel : 2'd3),
      .o_a1    (w_a1[i]),
      .o_a2    (w_a2[i]),
      .o_b1    (w_b1[i]),
      .o_b2    (w_b2[i])
    );
  end
  assign a1 = w_a1[0] | w_a1[1];
  assign a2 = w_a2[0] | w_a2[1];
  assign b1 = w_b1[0] | w_b1[1];
  assign b2 = w_b2[0] | w_b2[1];
`else
  assign w_start = w_idle && w_last;
  assign in_ready = w_idle;
  systolic_operand_buf #(.DW(DW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_xfer),
    .i_widx  (r_cnt),
    .i_wdata (in_data),
    .i_sel   (w_sel),
    .o_a1    (a1),
    .o_a2    (a2),
    .o_b1    (b1),
    .o_b2    (b2)
  );
`endif
endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// tb_systolic_feeder_2x2: directed scoreboard bench for the systolic feeder with a small 2x2 core model
module tb_systolic_feeder_2x2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic arr_done = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, arr_run, busy, timeout_err;
  logic [7:0] a1, a2, b1, b2;
  logic [63:0] sb [$];
  logic [7:0] job [8];
  logic [7:0] d_a1, d_a2, d_b1, d_b2;
  logic [15:0] c [4];
  logic [63:0] e;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  systolic_feeder_2x2 dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .arr_done(arr_done), .arr_run(arr_run), .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .busy(busy), .timeout_err(timeout_err)
  );
  // output-stationary 2x2 core: row/column operands propagate one PE per cycle, cleared while not running
  always @(posedge clk)
    if (!arr_run) begin
      for (int k = 0; k < 4; k++) c[k] <= '0;
      d_a1 <= '0; d_a2 <= '0; d_b1 <= '0; d_b2 <= '0;
    end else begin
      c[0] <= c[0] + a1 * b1;
      c[1] <= c[1] + d_a1 * b2;
      c[2] <= c[2] + a2 * d_b1;
      c[3] <= c[3] + d_a2 * d_b2;
      d_a1 <= a1; d_a2 <= a2; d_b1 <= b1; d_b2 <= b2;
    end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] mm();
    logic [15:0] c00, c01, c10, c11;
    c00 = 16'(job[0]) * job[4] + 16'(job[1]) * job[6];
    c01 = 16'(job[0]) * job[5] + 16'(job[1]) * job[7];
    c10 = 16'(job[2]) * job[4] + 16'(job[3]) * job[6];
    c11 = 16'(job[2]) * job[5] + 16'(job[3]) * job[7];
    return {c00, c01, c10, c11};
  endfunction
  task automatic fill(input int base, input bit rnd);
    for (int i = 0; i < 8; i++) job[i] = rnd ? 8'($urandom) : 8'(base + i);
  endtask
  task automatic send(input bit stall, input bit push);
    if (push) begin
      sb.push_back({32'h0, job[0], 8'h0, job[4], 8'h0});
      sb.push_back({32'h0, job[1], job[2], job[6], job[5]});
      sb.push_back({32'h0, 8'h0, job[3], 8'h0, job[7]});
      sb.push_back(64'h0);
    end
    for (int i = 0; i < 8; i++) begin
      if (stall) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      chk($sformatf("load_rdy%0d", i), in_ready, 1);
      in_valid = 1'b1;
      in_data = job[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask
  task automatic check_feed();
    for (int k = 0; k < 4; k++) begin
      e = (sb.size() != 0) ? sb.pop_front() : 64'hx;
      chk($sformatf("feed%0d", k), {a1, a2, b1, b2}, e);
      @(negedge clk);
    end
  endtask
  task automatic done_job();
    chk("core_c", {c[0], c[1], c[2], c[3]}, mm());
    chk("drain_run", arr_run, 1);
    arr_done = 1'b1;
    @(negedge clk);
    arr_done = 1'b0;
    chk("done_run", arr_run, 0);
    chk("done_busy", busy, 0);
    chk("done_rdy", in_ready, 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", {a1, a2, b1, b2}, 0);
    chk("rst_run", arr_run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_rdy", in_ready, 1);
    rst = 1'b0;
    fill(1, 0);
    send(0, 1);
`ifndef FEEDER_PINGPONG_EN
    chk("feed_rdy", in_ready, 0);
`endif
    chk("feed_run", arr_run, 1);
    chk("feed_busy", busy, 1);
    check_feed();
    chk("core_c_basic", {c[0], c[1], c[2], c[3]}, {16'd19, 16'd22, 16'd43, 16'd50});
    done_job();
    fill(9, 0);
    arr_done = 1'b1;
    send(1, 1);
    arr_done = 1'b0;
    check_feed();
    done_job();
    fill(0, 1);
    send(0, 1);
    check_feed();
    chk("tmo_early", timeout_err, 0);
    repeat (6) @(negedge clk);
    chk("tmo_d8_busy", busy, 1);
    chk("tmo_d8", timeout_err, 0);
    @(negedge clk);
    chk("tmo_set", timeout_err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_rdy", in_ready, 1);
    fill(0, 1);
    send(1, 1);
    check_feed();
    done_job();
    chk("tmo_sticky", timeout_err, 1);
    fill(0, 1);
    send(0, 1);
    e = sb.pop_front();
    chk("rst_feed0", {a1, a2, b1, b2}, e);
    @(negedge clk);
    e = sb.pop_front();
    chk("rst_feed1", {a1, a2, b1, b2}, e);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("midrst_out", {a1, a2, b1, b2}, 0);
    chk("midrst_run", arr_run, 0);
    chk("midrst_rdy", in_ready, 1);
    chk("midrst_tmo", timeout_err, 0);
    fill(0, 1);
    send(0, 1);
    check_feed();
    done_job();
`ifdef FEEDER_PINGPONG_EN
    fill(40, 0);
    send(0, 0);
    fill(60, 0);
    send(0, 1);
    chk("pp_full_rdy", in_ready, 0);
    arr_done = 1'b1;
    @(negedge clk);
    arr_done = 1'b0;
    chk("pp_gap_run", arr_run, 0);
    @(negedge clk);
    chk("pp_run", arr_run, 1);
    check_feed();
    done_job();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
